alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Downstream stage of the ALU. Accepts completed ALU results through a valid/ready handshake and holds them in a small FIFO.
- Emits results one word per beat toward writeback. Wide results (multiply upper/lower, divide quotient/remainder) are split into two beats.
- Holds the architectural status register. Its value feeds back to the ALU statusIn input.

Parameters:
- WIDTH, 32, datapath word width (result, upper, out_data)
- OPW, 4, opcode width carried alongside each result
- STW, 4, status flag width
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  buffer can accept
- in_opcode  in  OPW  opcode that produced the result
- in_lower  in  WIDTH  result / product low / quotient
- in_upper  in  WIDTH  product high / remainder; ignored when in_wide=0
- in_wide  in  1  1 = two-word result
- in_status  in  STW  ALU statusOut for this op
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts beat
- out_data  out  WIDTH  current beat word
- out_opcode  out  OPW  opcode of current entry
- out_last  out  1  final beat of current entry
- status_q  out  STW  architectural status register, to ALU statusIn
- count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): rd/wr pointers=0, count=0, beat=0, status_q=0, out_valid=0, out_data=0, out_opcode=0, out_last=0. in_ready reads 1 once rst_n is high.
- Reset mid-operation discards all entries and any partially emitted wide entry.
- Push: in_valid & in_ready at an edge writes {opcode, lower, upper, wide} at wr_ptr. wr_ptr wraps mod DEPTH.
- Status: status_q <= in_status on the same edge as the push. It is never updated otherwise.
- in_ready = (count < DEPTH). It depends only on registered count; there is no same-cycle bypass when full.
- A full buffer with a simultaneous pop still deasserts in_ready that cycle.
- Latency: an entry pushed at edge N is visible at the head with out_valid=1 from edge N onward (registered). out_valid = (count != 0). There is no combinational in-to-out path.
- Serializer state: beat ∈ {0,1}.
  - beat=0: out_data = head.lower; out_last = ~head.wide.
  - beat=1: out_data = head.upper; out_last = 1.
- On out_valid & out_ready:
  - if out_last: pop head (rd_ptr++ wraps, count--), beat <= 0;
  - else beat <= 1 (no pop).
- out_valid & ~out_ready: out_data, out_opcode, out_last and beat hold stable until accepted.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Empty: out_valid=0; out_data/out_opcode/out_last hold the last head value. Consumers must ignore them.
- count = number of stored entries (0..DEPTH), not beats.
- A push into an empty buffer with out_ready=1 is emitted no earlier than the cycle after the push edge.

Test Plan:
- Reset then single narrow push (opcode=2, lower=0x0000_0005, status=4'b0001): next cycle out_valid=1, out_data=5, out_last=1, status_q=1. out_ready=1 pops; count returns 0.
- Wide push (opcode=6, lower=0xDEAD_BEEF, upper=0x0000_0001) with out_ready=1: two consecutive beats 0xDEADBEEF (last=0) then 0x00000001 (last=1). count=1 → 0 only after the second beat.
- Fill with 4 narrow pushes, out_ready=0: in_ready=0 once count=4. A fifth in_valid is not accepted. Release out_ready: entries emerge in order. in_ready re-asserts the cycle after the first pop.
- Full buffer with simultaneous in_valid and pop: in_ready=0 blocks the push that cycle; count goes 4→3.
- Pointer wrap: 10 alternating narrow/wide pushes with randomized out_ready. Output sequence matches a reference queue exactly, and status_q equals in_status of the last accepted push.
- Assert rst_n low between the two beats of a wide entry, asynchronously mid-cycle. Outputs drop immediately: out_valid=0, count=0, status_q=0. After release, a new narrow push emits on beat 0 only.

Source files
------------

// File: rtl/alu_result_buffer.sv
// Result buffer between the ALU and writeback: a DEPTH-entry FIFO of ALU results
// that emits one word per beat, with wide results split into lower then upper beats.
// Latency: an entry pushed at edge N is presented from edge N on (registered head), never combinationally.
// Backpressure: in_ready = (count < DEPTH) from registered count only; out_ready low holds the current beat.
//
// Ports: clk/rst_n (async active-low); in_* = ALU result handshake and payload;
//        out_* = beat stream toward writeback; status_q = architectural status (to ALU statusIn);
//        count = stored entries (not beats).
module alu_result_buffer #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int STW   = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPW-1:0]             in_opcode,
    input  logic [WIDTH-1:0]           in_lower,
    input  logic [WIDTH-1:0]           in_upper,
    input  logic                       in_wide,
    input  logic [STW-1:0]             in_status,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [OPW-1:0]             out_opcode,
    output logic                       out_last,
    output logic [STW-1:0]             status_q,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [OPW-1:0]   opcode;
        logic [WIDTH-1:0] lower;
        logic [WIDTH-1:0] upper;
        logic             wide;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            beat;

    logic            push;
    logic            pop;
    logic            xfer;
    logic [AW-1:0]   rd_nxt;
    logic [CW-1:0]   count_nxt;
    logic            beat_nxt;
    entry_t          in_entry;
    entry_t          head_nxt;

    assign count     = count_q;
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign pop       = xfer & out_last;

    always_comb begin
        in_entry        = '0;
        in_entry.opcode = in_opcode;
        in_entry.lower  = in_lower;
        in_entry.upper  = in_upper;
        in_entry.wide   = in_wide;

        rd_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;

        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase

        // A beat handshake either finishes the entry (back to beat 0) or moves to its upper word.
        beat_nxt = beat;
        if (xfer) begin
            beat_nxt = ~out_last;
        end

        // The head after this edge is the incoming word only when every older entry is gone;
        // otherwise it is already in storage. Full-without-pop cannot alias since push is blocked.
        if (push && (rd_nxt == wr_ptr)) begin
            head_nxt = in_entry;
        end else begin
            head_nxt = mem[rd_nxt];
        end
    end

    // Storage carries no reset: contents are only meaningful behind count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            beat       <= 1'b0;
            status_q   <= '0;
            out_data   <= '0;
            out_opcode <= '0;
            out_last   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                status_q <= in_status;
            end
            rd_ptr  <= rd_nxt;
            count_q <= count_nxt;
            beat    <= beat_nxt;
            // Present the post-edge head; when the buffer drains the last values are left in place.
            if (count_nxt != '0) begin
                out_opcode <= head_nxt.opcode;
                out_data   <= beat_nxt ? head_nxt.upper : head_nxt.lower;
                out_last   <= beat_nxt | ~head_nxt.wide;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

    localparam int W     = 32;
    localparam int OPW   = 4;
    localparam int STW   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_opcode;
    logic [W-1:0]     in_lower;
    logic [W-1:0]     in_upper;
    logic             in_wide;
    logic [STW-1:0]   in_status;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [OPW-1:0]   out_opcode;
    logic             out_last;
    logic [STW-1:0]   status_q;
    logic [CW-1:0]    count;

    alu_result_buffer #(.WIDTH(W), .OPW(OPW), .STW(STW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_lower   (in_lower),
        .in_upper   (in_upper),
        .in_wide    (in_wide),
        .in_status  (in_status),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_opcode (out_opcode),
        .out_last   (out_last),
        .status_q   (status_q),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [W-1:0]   data;
        logic [OPW-1:0] op;
        logic           last;
    } beat_t;

    beat_t          exp_q[$];
    logic [STW-1:0] model_status;
    int             checks;
    int             errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entries still owed to the consumer = beats remaining that close an entry.
    function automatic int model_entries();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].last) n++;
        return n;
    endfunction

    // Monitor: every presented beat must match the scoreboard head; accepted beats retire it.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h op %0h last %0b with empty scoreboard", out_data, out_opcode, out_last);
            end else begin
                check("out_beat", 64'({out_data, out_opcode, out_last}), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus, started at posedge+1. Occupancy-derived flags are checked
    // against the model before the cycle's own push is recorded.
    task automatic step(input logic v, input logic [OPW-1:0] op, input logic [W-1:0] lo,
                        input logic [W-1:0] up, input logic wd, input logic [STW-1:0] st,
                        input logic ordy, output logic acc);
        int ent;
        logic mrdy;
        beat_t b;
        in_valid  = v;
        in_opcode = op;
        in_lower  = lo;
        in_upper  = up;
        in_wide   = wd;
        in_status = st;
        out_ready = ordy;
        #2;
        ent  = model_entries();
        mrdy = (ent < DEPTH);
        check("in_ready",  64'(in_ready),  64'(mrdy));
        check("count",     64'(count),     64'(ent));
        check("out_valid", 64'(out_valid), 64'(ent != 0));
        check("status_q",  64'(status_q),  64'(model_status));
        acc = v && mrdy;
        if (acc) begin
            if (wd) begin
                b = '{data: lo, op: op, last: 1'b0};
                exp_q.push_back(b);
                b = '{data: up, op: op, last: 1'b1};
                exp_q.push_back(b);
            end else begin
                b = '{data: lo, op: op, last: 1'b1};
                exp_q.push_back(b);
            end
            model_status = st;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, '0, '0, '0, 1'b0, '0, ordy, acc);
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            idle(1'b1);
            budget++;
        end
        check("drained", 64'(exp_q.size()), 64'(0));
        idle(1'b1);
    endtask

    initial begin
        logic acc;
        logic [STW-1:0] last_st;
        checks       = 0;
        errors       = 0;
        model_status = '0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_opcode    = '0;
        in_lower     = '0;
        in_upper     = '0;
        in_wide      = 1'b0;
        in_status    = '0;
        out_ready    = 1'b0;

        #12;
        check("rst_out_valid",  64'(out_valid),  64'(0));
        check("rst_count",      64'(count),      64'(0));
        check("rst_status_q",   64'(status_q),   64'(0));
        check("rst_out_data",   64'(out_data),   64'(0));
        check("rst_out_opcode", 64'(out_opcode), 64'(0));
        check("rst_out_last",   64'(out_last),   64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single narrow push, consumed as soon as it appears.
        step(1'b1, 4'd2, 32'h0000_0005, 32'h0, 1'b0, 4'b0001, 1'b1, acc);
        check("narrow_accepted", 64'(acc), 64'(1));
        drain();

        // Wide push: two consecutive beats, entry retires after the upper word.
        step(1'b1, 4'd6, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 4'b0010, 1'b1, acc);
        drain();

        // Fill to DEPTH with the consumer stalled, then offer a fifth.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, OPW'(i + 1), W'(32'h100 + i), '0, 1'b0, STW'(i), 1'b0, acc);
        end
        step(1'b1, 4'hF, 32'hBAD0_0000, '0, 1'b0, 4'hF, 1'b0, acc);
        check("fifth_rejected", 64'(acc), 64'(0));
        // Full with a simultaneous pop: still no push this cycle.
        step(1'b1, 4'hE, 32'hBAD0_0001, '0, 1'b0, 4'hE, 1'b1, acc);
        check("full_pop_rejected", 64'(acc), 64'(0));
        drain();

        // Pointer wrap: alternating narrow/wide entries under random consumer stalls.
        last_st = model_status;
        for (int i = 0; i < 10; i++) begin
            logic [OPW-1:0] op;
            logic [W-1:0]   lo;
            logic [W-1:0]   up;
            logic [STW-1:0] st;
            int tries = 0;
            op = OPW'($urandom);
            lo = $urandom;
            up = $urandom;
            st = STW'($urandom);
            acc = 1'b0;
            while (!acc && tries < 50) begin
                step(1'b1, op, lo, up, logic'(i % 2), st, logic'($urandom_range(0, 1)), acc);
                tries++;
            end
            check("wrap_push_accepted", 64'(acc), 64'(1));
            if (acc) last_st = st;
        end
        drain();
        check("status_last_push", 64'(status_q), 64'(last_st));

        // Asynchronous reset between the two beats of a wide entry.
        step(1'b1, 4'd9, 32'h1111_2222, 32'h3333_4444, 1'b1, 4'b1010, 1'b0, acc);
        idle(1'b1);
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_count",     64'(count),     64'(0));
        check("arst_status_q",  64'(status_q),  64'(0));
        exp_q.delete();
        model_status = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 4'd3, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0, 4'b0100, 1'b1, acc);
        drain();
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
